glitch_sequencer: RTL
=====================

Name: glitch_sequencer

Overview:
Sequences the 64-bit glitch-waveform serializer for one glitch event. The block holds a small bank of 64-bit pattern words. Once armed, it waits for an external target trigger, counts a programmable delay, then streams a programmed number of pattern words through the serializer, one word at a time. It sits between the host configuration registers and the serializer instance, and owns that instance's en and in inputs.

Parameters:
NUM_WORDS, 4, number of pattern slots (power of 2, ≥2)
DELAY_W, 32, width of the trigger-to-glitch delay counter
SER_CYCLES, 66, cycles ser_en is held per word (covers serializer load + 64 bits + return to idle)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  pattern-slot write strobe
cfg_addr  in  $clog2(NUM_WORDS)  slot index for cfg_we
cfg_data  in  64  pattern word; bit 63 is emitted first
delay  in  DELAY_W  trigger-to-first-word delay in cycles; sampled on arm
word_count  in  $clog2(NUM_WORDS)+1  words to emit; sampled on arm; legal range 0..NUM_WORDS
arm  in  1  single-cycle arm request
abort  in  1  cancel from any state
trigger  in  1  target trigger, already synchronised to clk; rising edge is used
ser_en  out  1  drives the serializer en input
ser_data  out  64  drives the serializer in input
armed  out  1  high while waiting for trigger
busy  out  1  high from trigger accept until done
done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (async, active-high): state IDLE. ser_en=0, ser_data=0, armed=0, busy=0, done=0. Trigger edge register = 0. Pattern bank = 0.
- All outputs are registered.
- cfg_we writes the slot only in IDLE or ARMED. It is ignored in every other state.
- States: IDLE, ARMED, DELAY, LOAD, SHIFT, GAP, DONE.
- IDLE, arm=1:
  - latch delay and word_count;
  - word_count clamped to NUM_WORDS if larger;
  - latched count = 0 -> go to DONE (no serializer activity);
  - otherwise -> ARMED.
- ARMED: armed=1. Rising edge (trigger=1 and previous sample=0) -> DELAY, or LOAD if delay=0. A trigger already high at arm time is not an edge. arm in ARMED re-latches delay and word_count.
- DELAY: busy=1. Counts exactly `delay` cycles, then LOAD. Trigger edges are ignored.
- LOAD: ser_data <= slot[idx], ser_en <= 1, then SHIFT.
- SHIFT: ser_en held high for SER_CYCLES cycles in total, ser_data stable, then GAP.
- GAP: ser_en=0 for exactly 1 cycle; idx++. If idx == latched count -> DONE, else LOAD.
- DONE: done=1 for one cycle, busy=0, then IDLE. idx cleared.
- Timing: with the trigger-sampling edge counted as edge 0, ser_en first rises at edge delay+2. Each following word rises SER_CYCLES+1 cycles after the previous one.
- abort (highest priority, any state): next edge -> IDLE; ser_en=0, armed=0, busy=0; no done pulse. ser_data keeps its last value.
- abort and arm in the same cycle: abort wins.
- Counters never wrap. Delay counter width is DELAY_W. Max delay is 2^DELAY_W-1.

Optional Feature:
GLITCH_SEQ_REARM_EN
- Defined: DONE returns to ARMED, not IDLE. The latched delay and count are retained, giving a repeated glitch on each trigger edge until abort. done still pulses each pass.
- Undefined: DONE -> IDLE as above.

Test Plan:
- Write slot0=64'hFFFF_0000_FFFF_0000, word_count=1, delay=0, arm, trigger edge at edge 0 -> ser_en rises at edge 2, held 66 cycles, ser_data=slot0; done pulses once; busy low afterwards.
- word_count=3, delay=10, slots 0..2 distinct -> ser_en rises at edge 12; three 66-cycle windows separated by 1-cycle gaps; ser_data steps slot0→slot1→slot2; done at the end.
- Trigger held high during arm, then low, then high -> only the later rising edge starts the sequence; a second edge during DELAY has no effect.
- abort asserted mid-SHIFT of word 2 -> ser_en=0 next cycle, state IDLE, no done pulse; a fresh arm+trigger runs normally.
- word_count=0, arm -> done pulse within 2 cycles, ser_en never asserted. cfg_we during SHIFT -> slot unchanged (verified by a second run).
- GLITCH_SEQ_REARM_EN defined: two trigger edges after one arm -> two full sequences, two done pulses, armed=1 between them.

Source files
------------

// File: rtl/glitch_sequencer_if.sv
// glitch_sequencer_if: configuration, control and serializer-drive signals of the
// glitch sequencer, bundled for connection between a host and the sequencer.
//   slave  modport: seen by glitch_sequencer (config/control in, serializer drive/status out)
//   master modport: seen by the host side (config/control out, serializer drive/status in)
// Signals:
//   cfg_we, cfg_addr, cfg_data : pattern-slot write port
//   delay, word_count          : run parameters, sampled on arm
//   arm, abort, trigger        : control (trigger already synchronised to clk)
//   ser_en, ser_data           : serializer en / in drive
//   armed, busy, done          : status
interface glitch_sequencer_if #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned DELAY_W   = 32
);
    localparam int unsigned AW = $clog2(NUM_WORDS);

    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [63:0]       cfg_data;
    logic [DELAY_W-1:0] delay;
    logic [AW:0]       word_count;
    logic              arm;
    logic              abort;
    logic              trigger;
    logic              ser_en;
    logic [63:0]       ser_data;
    logic              armed;
    logic              busy;
    logic              done;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, delay, word_count, arm, abort, trigger,
        output ser_en, ser_data, armed, busy, done
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, delay, word_count, arm, abort, trigger,
        input  ser_en, ser_data, armed, busy, done
    );
endinterface

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: sequences the 64-bit glitch-waveform serializer for one glitch event.
// Holds NUM_WORDS pattern words. Once armed it waits for a trigger rising edge, counts the
// latched delay, then streams the latched number of words, each with ser_en held for
// SER_CYCLES cycles followed by a one-cycle gap.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : glitch_sequencer_if.slave (config, arm/abort/trigger, ser_en/ser_data, status)
// Optional feature macro: GLITCH_SEQ_REARM_EN -- when defined, a completed sequence returns
// to ARMED with the latched delay/count kept, so every further trigger edge repeats it.
module glitch_sequencer #(
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned DELAY_W    = 32,
    parameter int unsigned SER_CYCLES = 66
) (
    input  logic                clk,
    input  logic                rst,
    glitch_sequencer_if.slave   bus
);
    localparam int unsigned AW = $clog2(NUM_WORDS);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(SER_CYCLES);

    localparam logic [CW-1:0] MaxCount  = CW'(NUM_WORDS);
    localparam logic [SW-1:0] ShiftLoad = SW'(SER_CYCLES - 2);

    typedef enum logic [2:0] {
        StIdle, StArmed, StDelay, StLoad, StShift, StGap, StDone
    } state_e;

    state_e              state_q, state_d;
    logic                trig_q, trig_d;
    logic                trig_prev_q, trig_prev_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [CW-1:0]       count_q, count_d;
    logic [DELAY_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic [SW-1:0]       shift_cnt_q, shift_cnt_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [63:0]         bank_q [NUM_WORDS];
    logic [63:0]         bank_d [NUM_WORDS];
    logic                ser_en_q, ser_en_d;
    logic [63:0]         ser_data_q, ser_data_d;
    logic                armed_q, armed_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                trig_rise;
    logic [CW-1:0]       wc_clamped;
    logic [CW-1:0]       idx_next;
    logic                cfg_open;
    logic                arm_take;

    // Trigger is sampled into trig_q; the edge is seen one cycle later, which places the
    // first ser_en rise at edge delay+2 counting the sampling edge as edge 0.
    assign trig_d      = bus.trigger;
    assign trig_prev_d = trig_q;
    assign trig_rise   = trig_q & ~trig_prev_q;

    assign wc_clamped = (bus.word_count > MaxCount) ? MaxCount : bus.word_count;
    assign idx_next   = idx_q + 1'b1;
    assign cfg_open   = (state_q == StIdle) || (state_q == StArmed);
    assign arm_take   = bus.arm && !bus.abort && cfg_open;

    // State register and all flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            trig_q      <= 1'b0;
            trig_prev_q <= 1'b0;
            delay_q     <= '0;
            count_q     <= '0;
            dly_cnt_q   <= '0;
            shift_cnt_q <= '0;
            idx_q       <= '0;
            ser_en_q    <= 1'b0;
            ser_data_q  <= '0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            trig_q      <= trig_d;
            trig_prev_q <= trig_prev_d;
            delay_q     <= delay_d;
            count_q     <= count_d;
            dly_cnt_q   <= dly_cnt_d;
            shift_cnt_q <= shift_cnt_d;
            idx_q       <= idx_d;
            ser_en_q    <= ser_en_d;
            ser_data_q  <= ser_data_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int i = 0; i < NUM_WORDS; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    // Next-state logic. abort overrides everything.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.arm) begin
                        state_d = (wc_clamped == '0) ? StDone : StArmed;
                    end
                end
                StArmed: begin
                    // A re-arm takes precedence over a trigger edge in the same cycle.
                    if (bus.arm) begin
                        state_d = (wc_clamped == '0) ? StDone : StArmed;
                    end else if (trig_rise) begin
                        state_d = (delay_q == '0) ? StLoad : StDelay;
                    end
                end
                StDelay: begin
                    if (dly_cnt_q == DELAY_W'(1)) begin
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    state_d = StShift;
                end
                StShift: begin
                    if (shift_cnt_q == '0) begin
                        state_d = StGap;
                    end
                end
                StGap: begin
                    state_d = (idx_next == count_q) ? StDone : StLoad;
                end
                StDone: begin
`ifdef GLITCH_SEQ_REARM_EN
                    // A zero-length run has nothing to repeat.
                    state_d = (count_q != '0) ? StArmed : StIdle;
`else
                    state_d = StIdle;
`endif
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Datapath: latched run parameters, counters, word index and pattern bank.
    always_comb begin
        delay_d     = delay_q;
        count_d     = count_q;
        dly_cnt_d   = dly_cnt_q;
        shift_cnt_d = shift_cnt_q;
        idx_d       = idx_q;
        for (int i = 0; i < NUM_WORDS; i++) begin
            bank_d[i] = bank_q[i];
        end

        if (bus.cfg_we && cfg_open) begin
            bank_d[bus.cfg_addr] = bus.cfg_data;
        end

        if (arm_take) begin
            delay_d = bus.delay;
            count_d = wc_clamped;
        end

        // Reloaded every ARMED cycle so it always reflects the latched delay at trigger.
        if (state_q == StArmed) begin
            dly_cnt_d = delay_q;
        end else if (state_q == StDelay) begin
            dly_cnt_d = dly_cnt_q - 1'b1;
        end

        // LOAD plus SER_CYCLES-1 SHIFT cycles give SER_CYCLES cycles of ser_en.
        if (state_q == StLoad) begin
            shift_cnt_d = ShiftLoad;
        end else if (state_q == StShift && shift_cnt_q != '0) begin
            shift_cnt_d = shift_cnt_q - 1'b1;
        end

        if (bus.abort || state_q == StIdle || state_q == StDone) begin
            idx_d = '0;
        end else if (state_q == StGap) begin
            idx_d = idx_next;
        end
    end

    // Output logic. The serializer drive follows the current state (the word fetched in
    // LOAD appears on the following edge); status follows the next state.
    always_comb begin
        ser_en_d   = !bus.abort && (state_q == StLoad || state_q == StShift);
        ser_data_d = ser_data_q;
        if (!bus.abort && state_q == StLoad) begin
            ser_data_d = bank_q[idx_q[AW-1:0]];
        end
        armed_d = (state_d == StArmed);
        busy_d  = (state_d == StDelay) || (state_d == StLoad) ||
                  (state_d == StShift) || (state_d == StGap);
        done_d  = (state_d == StDone);
    end

    assign bus.ser_en   = ser_en_q;
    assign bus.ser_data = ser_data_q;
    assign bus.armed    = armed_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
